alu_sequencer: RTL and testbench

- Issue and writeback controller on the initiator side of the ALU interface.
- Accepts one decoded-stream opcode byte per instruction, plus a CB-prefix marker.
- Per instruction it:
  - derives the ALU control fields;
  - fetches operands from the register file;
  - sequences the ALU through T-cycles 0-3 and fires the alu_begin edge;
  - writes the result and flags back.
- Owns the F (flags) register and supplies it to the ALU.

---
 rtl/alu_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Issue/writeback controller driving the ALU through T-cycles 0-3 and owning the F register.
// Optional back-to-back issue from WB is enabled by defining ALU_SEQ_PIPE_EN.
module alu_sequencer #(
  parameter logic [7:0] F_RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [7:0] opcode,
  input  logic       op_cb,
  output logic       op_done,
  output logic       op_illegal,
  output logic [2:0] rf_src_idx,
  input  logic [7:0] rf_src_data,
  input  logic [7:0] rf_a_data,
  output logic       rf_wr_en,
  output logic [2:0] rf_wr_idx,
  output logic [7:0] rf_wr_data,
  output logic [7:0] flags_out,
  output logic [1:0] alu_t_cycle,
  output logic [2:0] alu_op,
  output logic       alu_begin,
  output logic [7:0] alu_src_data,
  output logic [7:0] alu_dest_data,
  output logic [2:0] alu_bit_index,
  output logic [7:0] alu_flags_in,
  output logic       alu_incdec,
  output logic       alu_ext,
  output logic       alu_misc,
  input  logic [7:0] alu_res,
  input  logic [7:0] alu_flags_res,
  input  logic       alu_wr_en_flags
);

  typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_WB} state_t;

  state_t     r_state;
  logic [7:0] r_opcode;
  logic       r_cb;
  logic [7:0] r_f;
  logic       r_wr_pend;
  logic       r_op_done;
  logic       r_op_illegal;
  logic [2:0] r_rf_src_idx;
  logic       r_rf_wr_en;
  logic [2:0] r_rf_wr_idx;
  logic [7:0] r_rf_wr_data;
  logic [1:0] r_t_cycle;
  logic [2:0] r_alu_op;
  logic       r_alu_begin;
  logic [7:0] r_alu_src;
  logic [7:0] r_alu_dest;
  logic [2:0] r_alu_bit;
  logic       r_alu_incdec;
  logic       r_alu_ext;
  logic       r_alu_misc;

  logic       w_illegal;
  logic [2:0] w_op;
  logic       w_ext;
  logic       w_misc;
  logic       w_incdec;
  logic [2:0] w_bidx;
  logic [2:0] w_src;
  logic       w_wr;
  logic [2:0] w_widx;

  // Decode of the latched instruction byte, consumed in T0.
  always_comb begin
    w_illegal = 1'b0;
    w_op      = r_opcode[5:3];
    w_ext     = r_cb;
    w_misc    = 1'b0;
    w_incdec  = 1'b0;
    w_bidx    = '0;
    w_src     = r_opcode[2:0];
    w_wr      = 1'b0;
    w_widx    = r_opcode[2:0];
    if (r_cb) begin
      w_illegal = (r_opcode[2:0] == 3'd6);
      case (r_opcode[7:6])
        2'b00: w_wr = 1'b1;
        2'b01: begin
          w_misc = 1'b1;
          w_op   = 3'b001;
          w_bidx = r_opcode[5:3];
        end
        default: begin
          w_misc = 1'b1;
          w_op   = {1'b0, r_opcode[7:6]};
          w_bidx = r_opcode[5:3];
          w_wr   = 1'b1;
        end
      endcase
    end else if (r_opcode[7:6] == 2'b10) begin
      w_illegal = (r_opcode[2:0] == 3'd6);
      w_wr      = (r_opcode[5:3] != 3'b111);
      w_widx    = 3'd7;
    end else if (r_opcode[7:6] == 2'b00 && r_opcode[2:1] == 2'b10) begin
      w_illegal = (r_opcode[5:3] == 3'd6);
      w_incdec  = 1'b1;
      w_misc    = 1'b1;
      w_op      = {2'b10, r_opcode[0]};
      w_src     = r_opcode[5:3];
      w_widx    = r_opcode[5:3];
      w_wr      = 1'b1;
    end else if (r_opcode[7:6] == 2'b00 && r_opcode[2:0] == 3'b111) begin
      w_misc = 1'b1;
      w_src  = 3'd7;
      w_widx = 3'd7;
      w_wr   = (r_opcode[5:3] <= 3'd5);
    end else begin
      w_illegal = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_opcode     <= '0;
      r_cb         <= 1'b0;
      r_f          <= F_RESET_VAL & 8'hF0;
      r_wr_pend    <= 1'b0;
      r_op_done    <= 1'b0;
      r_op_illegal <= 1'b0;
      r_rf_src_idx <= '0;
      r_rf_wr_en   <= 1'b0;
      r_rf_wr_idx  <= '0;
      r_rf_wr_data <= '0;
      r_t_cycle    <= '0;
      r_alu_op     <= '0;
      r_alu_begin  <= 1'b0;
      r_alu_src    <= '0;
      r_alu_dest   <= '0;
      r_alu_bit    <= '0;
      r_alu_incdec <= 1'b0;
      r_alu_ext    <= 1'b0;
      r_alu_misc   <= 1'b0;
    end else begin
      r_op_done    <= 1'b0;
      r_op_illegal <= 1'b0;
      r_rf_wr_en   <= 1'b0;
      r_alu_begin  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (op_valid) begin
            r_opcode <= opcode;
            r_cb     <= op_cb;
            r_state  <= S_T0;
          end
        end
        S_T0: begin
          if (w_illegal) begin
            r_op_illegal <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_alu_op     <= w_op;
            r_alu_ext    <= w_ext;
            r_alu_misc   <= w_misc;
            r_alu_incdec <= w_incdec;
            r_alu_bit    <= w_bidx;
            r_rf_src_idx <= w_src;
            r_wr_pend    <= w_wr;
            r_rf_wr_idx  <= w_widx;
            r_t_cycle    <= 2'd1;
            r_state      <= S_T1;
          end
        end
        S_T1: begin
          r_alu_src   <= rf_src_data;
          r_alu_dest  <= rf_a_data;
          r_alu_begin <= 1'b1;
          r_t_cycle   <= 2'd2;
          r_state     <= S_T2;
        end
        S_T2: begin
          // Result is captured as WB is entered so the write strobe, index and data are all registered together.
          r_rf_wr_en   <= r_wr_pend;
          r_rf_wr_data <= alu_res;
          r_op_done    <= 1'b1;
          r_t_cycle    <= 2'd3;
          r_state      <= S_WB;
        end
        S_WB: begin
          if (alu_wr_en_flags) begin
            r_f <= {alu_flags_res[7:4], 4'h0};
          end
          r_t_cycle <= 2'd0;
`ifdef ALU_SEQ_PIPE_EN
          if (op_valid) begin
            r_opcode <= opcode;
            r_cb     <= op_cb;
            r_state  <= S_T0;
          end else begin
            r_state  <= S_IDLE;
          end
`else
          r_state <= S_IDLE;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_PIPE_EN
  assign op_ready = (r_state == S_IDLE) || (r_state == S_WB);
`else
  assign op_ready = (r_state == S_IDLE);
`endif

  assign op_done       = r_op_done;
  assign op_illegal    = r_op_illegal;
  assign rf_src_idx    = r_rf_src_idx;
  assign rf_wr_en      = r_rf_wr_en;
  assign rf_wr_idx     = r_rf_wr_idx;
  assign rf_wr_data    = r_rf_wr_data;
  assign flags_out     = r_f;
  assign alu_flags_in  = r_f;
  assign alu_t_cycle   = r_t_cycle;
  assign alu_op        = r_alu_op;
  assign alu_begin     = r_alu_begin;
  assign alu_src_data  = r_alu_src;
  assign alu_dest_data = r_alu_dest;
  assign alu_bit_index = r_alu_bit;
  assign alu_incdec    = r_alu_incdec;
  assign alu_ext       = r_alu_ext;
  assign alu_misc      = r_alu_misc;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed instructions, register-file and ALU stubs, queue-based monitor.
`timescale 1ns/1ps
module tb_alu_sequencer;

  localparam logic [7:0] FRST = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       op_valid;
  logic       op_ready;
  logic [7:0] opcode;
  logic       op_cb;
  logic       op_done;
  logic       op_illegal;
  logic [2:0] rf_src_idx;
  logic [7:0] rf_src_data;
  logic [7:0] rf_a_data;
  logic       rf_wr_en;
  logic [2:0] rf_wr_idx;
  logic [7:0] rf_wr_data;
  logic [7:0] flags_out;
  logic [1:0] alu_t_cycle;
  logic [2:0] alu_op;
  logic       alu_begin;
  logic [7:0] alu_src_data;
  logic [7:0] alu_dest_data;
  logic [2:0] alu_bit_index;
  logic [7:0] alu_flags_in;
  logic       alu_incdec;
  logic       alu_ext;
  logic       alu_misc;
  logic [7:0] alu_res;
  logic [7:0] alu_flags_res;
  logic       alu_wr_en_flags;

  alu_sequencer #(.F_RESET_VAL(FRST)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .opcode(opcode), .op_cb(op_cb), .op_done(op_done), .op_illegal(op_illegal),
    .rf_src_idx(rf_src_idx), .rf_src_data(rf_src_data), .rf_a_data(rf_a_data),
    .rf_wr_en(rf_wr_en), .rf_wr_idx(rf_wr_idx), .rf_wr_data(rf_wr_data),
    .flags_out(flags_out), .alu_t_cycle(alu_t_cycle), .alu_op(alu_op),
    .alu_begin(alu_begin), .alu_src_data(alu_src_data), .alu_dest_data(alu_dest_data),
    .alu_bit_index(alu_bit_index), .alu_flags_in(alu_flags_in), .alu_incdec(alu_incdec),
    .alu_ext(alu_ext), .alu_misc(alu_misc), .alu_res(alu_res),
    .alu_flags_res(alu_flags_res), .alu_wr_en_flags(alu_wr_en_flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file stub: B0 C1 D2 E3 H4 L5 A7
  logic [7:0] regs [8];
  assign rf_src_data = regs[rf_src_idx];
  assign rf_a_data   = regs[7];
  always @(posedge clk) if (rf_wr_en) regs[rf_wr_idx] <= rf_wr_data;

  // ALU stub: ADD computed, everything else returns per-instruction constants
  logic [7:0] st_res, st_fres;
  logic       st_fwe;
  logic       is_add;
  logic [8:0] add_sum;
  logic [4:0] add_h;
  assign is_add  = (alu_op == 3'd0) && !alu_ext && !alu_misc && !alu_incdec;
  assign add_sum = {1'b0, alu_dest_data} + {1'b0, alu_src_data};
  assign add_h   = {1'b0, alu_dest_data[3:0]} + {1'b0, alu_src_data[3:0]};
  assign alu_res = is_add ? add_sum[7:0] : st_res;
  assign alu_flags_res = is_add ? {(add_sum[7:0] == 8'h00), 1'b0, add_h[4], add_sum[8], 4'h0} : st_fres;
  assign alu_wr_en_flags = (alu_t_cycle == 2'd3) && (is_add || st_fwe);

  typedef struct {
    string      name;
    logic       ill;
    logic       wr;
    logic [2:0] idx;
    logic [7:0] data;
    logic [7:0] f;
    logic [7:0] fin;
    logic [2:0] op;
    logic       ext, misc, incdec;
    logic       chkb;
    logic [2:0] bidx;
    logic       chks;
    logic [7:0] src;
    logic [7:0] dest;
    int         acc;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(input string name, input logic ill, input logic wr,
                              input logic [2:0] idx, input logic [7:0] data, input logic [7:0] f,
                              input logic [7:0] fin, input logic [2:0] op, input logic ext,
                              input logic misc, input logic incdec, input logic chkb,
                              input logic [2:0] bidx, input logic chks, input logic [7:0] src,
                              input logic [7:0] dest);
    exp_t e;
    e.name = name; e.ill = ill; e.wr = wr; e.idx = idx; e.data = data; e.f = f; e.fin = fin;
    e.op = op; e.ext = ext; e.misc = misc; e.incdec = incdec; e.chkb = chkb; e.bidx = bidx;
    e.chks = chks; e.src = src; e.dest = dest; e.acc = 0;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input exp_t e, input logic cb, input logic [7:0] opc,
                       input logic [7:0] res, input logic [7:0] fres, input logic fwe,
                       output int acc);
    int n = 0;
    st_res = res; st_fres = fres; st_fwe = fwe;
    opcode = opc; op_cb = cb; op_valid = 1'b1;
    while (!op_ready && n < 20) begin @(negedge clk); n++; end
    acc = -1;
    if (!op_ready) begin
      chk({e.name, " accept timeout"}, 0, 1);
    end else begin
      e.acc = cyc + 1;
      acc = e.acc;
      sbq.push_back(e);
      @(negedge clk);
    end
    op_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sbq.size() != 0 || !op_ready) && n < 40) begin @(negedge clk); n++; end
    if (sbq.size() != 0) begin
      chk("drain timeout", sbq.size(), 0);
      sbq.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: latency counted with the cycle that starts at the accept edge as cycle 1
  exp_t me;
  int   bcnt = 0;
  bit   fpend = 0;
  logic [7:0] fexp;
  string fname;
  always @(negedge clk) begin
    if (!rst_n) begin
      bcnt  = 0;
      fpend = 0;
    end else begin
      if (fpend) begin
        chk({fname, " flags_out"}, flags_out, fexp);
        chk({fname, " alu_flags_in"}, alu_flags_in, fexp);
        fpend = 0;
      end
      if (rf_wr_en) chk("rf_wr_en outside writeback", op_done, 1);
      if (alu_begin) begin
        bcnt++;
        if (sbq.size() == 0) chk("unexpected alu_begin", 1, 0);
        else if (bcnt == 1) begin
          me = sbq[0];
          chk({me.name, " begin latency"}, cyc - me.acc + 1, 3);
          chk({me.name, " t_cycle@begin"}, alu_t_cycle, 2);
          chk({me.name, " alu_op"}, alu_op, me.op);
          chk({me.name, " ext/misc/incdec"}, {alu_ext, alu_misc, alu_incdec}, {me.ext, me.misc, me.incdec});
          chk({me.name, " dest_data"}, alu_dest_data, me.dest);
          chk({me.name, " flags_in"}, alu_flags_in, me.fin);
          if (me.chks) chk({me.name, " src_data"}, alu_src_data, me.src);
          if (me.chkb) chk({me.name, " bit_index"}, alu_bit_index, me.bidx);
        end
      end
      if (op_done || op_illegal) begin
        if (sbq.size() == 0) chk("unexpected completion", 1, 0);
        else begin
          me = sbq.pop_front();
          chk({me.name, " op_illegal"}, op_illegal, me.ill);
          chk({me.name, " op_done"}, op_done, !me.ill);
          chk({me.name, " begin count"}, bcnt, me.ill ? 0 : 1);
          chk({me.name, " latency"}, cyc - me.acc + 1, me.ill ? 2 : 4);
          chk({me.name, " rf_wr_en"}, rf_wr_en, me.wr);
          if (me.wr) begin
            chk({me.name, " rf_wr_idx"}, rf_wr_idx, me.idx);
            chk({me.name, " rf_wr_data"}, rf_wr_data, me.data);
          end
          fpend = 1; fexp = me.f; fname = me.name;
        end
        bcnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, n;
    rst_n = 1'b0; op_valid = 1'b0; opcode = '0; op_cb = 1'b0;
    st_res = '0; st_fres = '0; st_fwe = 1'b0;
    regs[0] <= 8'hC6; regs[1] <= 8'h0F; regs[2] <= 8'hF1; regs[3] <= 8'hFF;
    regs[4] <= 8'h00; regs[5] <= 8'h00; regs[6] <= 8'h00; regs[7] <= 8'h3A;
    repeat (3) @(negedge clk);
    chk("reset op_ready", op_ready, 1);
    chk("reset flags_out", flags_out, 8'hA0);
    chk("reset begin/wr/done/ill", {alu_begin, rf_wr_en, op_done, op_illegal}, 0);
    chk("reset t_cycle", alu_t_cycle, 0);
    chk("reset alu ctl", {alu_op, alu_ext, alu_misc, alu_incdec, alu_bit_index}, 0);
    chk("reset alu data", {alu_src_data, alu_dest_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Abort an ADD in T2 with reset
    issue(mk("abort", 0, 1, 7, 8'h00, 8'hB0, 8'hA0, 0, 0, 0, 0, 0, 0, 1, 8'hC6, 8'h3A),
          1'b0, 8'h80, 8'h00, 8'h00, 1'b0, a1);
    n = 0;
    while (alu_t_cycle != 2'd2 && n < 10) begin @(negedge clk); n++; end
    chk("abort reached T2 begin", {alu_t_cycle, alu_begin}, {2'd2, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    chk("abort alu_begin", alu_begin, 0);
    chk("abort op_ready", op_ready, 1);
    chk("abort flags_out", flags_out, 8'hA0);
    chk("abort rf_wr_en", rf_wr_en, 0);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort A untouched", regs[7], 8'h3A);

    issue(mk("add_a_b", 0, 1, 7, 8'h00, 8'hB0, 8'hA0, 3'b000, 0, 0, 0, 0, 0, 1, 8'hC6, 8'h3A),
          1'b0, 8'h80, 8'h00, 8'h00, 1'b0, a1);
    wait_idle();
    issue(mk("inc_c", 0, 1, 1, 8'h10, 8'h30, 8'hB0, 3'b100, 0, 1, 1, 0, 0, 1, 8'h0F, 8'h00),
          1'b0, 8'h0C, 8'h10, 8'h30, 1'b1, a1);
    wait_idle();
    issue(mk("swap_d", 0, 1, 2, 8'h1F, 8'h00, 8'h30, 3'b110, 1, 0, 0, 0, 0, 1, 8'hF1, 8'h00),
          1'b1, 8'h32, 8'h1F, 8'h00, 1'b1, a1);
    wait_idle();
    issue(mk("scf", 0, 0, 0, 8'h00, 8'h10, 8'h00, 3'b110, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00),
          1'b0, 8'h37, 8'h00, 8'h1F, 1'b1, a1);
    wait_idle();
    issue(mk("bit7_h", 0, 0, 0, 8'h00, 8'hB0, 8'h10, 3'b001, 1, 1, 0, 1, 3'd7, 1, 8'h00, 8'h00),
          1'b1, 8'h7C, 8'h00, 8'hB0, 1'b1, a1);
    wait_idle();
    issue(mk("cp_b", 0, 0, 0, 8'h00, 8'h70, 8'hB0, 3'b111, 0, 0, 0, 0, 0, 1, 8'hC6, 8'h00),
          1'b0, 8'hB8, 8'hAA, 8'h75, 1'b1, a1);
    wait_idle();
    issue(mk("res0_e", 0, 1, 3, 8'hFE, 8'h70, 8'h70, 3'b010, 1, 1, 0, 1, 3'd0, 1, 8'hFF, 8'h00),
          1'b1, 8'h83, 8'hFE, 8'hF0, 1'b0, a1);
    wait_idle();
    issue(mk("ill_86", 1, 0, 0, 8'h00, 8'h70, 8'h70, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00),
          1'b0, 8'h86, 8'h00, 8'hF0, 1'b1, a1);
    wait_idle();
    issue(mk("ill_cb46", 1, 0, 0, 8'h00, 8'h70, 8'h70, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00),
          1'b1, 8'h46, 8'h00, 8'hF0, 1'b1, a1);
    wait_idle();
    issue(mk("ill_76", 1, 0, 0, 8'h00, 8'h70, 8'h70, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00),
          1'b0, 8'h76, 8'h00, 8'hF0, 1'b1, a1);
    wait_idle();
    chk("E after RES 0", regs[3], 8'hFE);
    chk("C after INC", regs[1], 8'h10);

`ifdef ALU_SEQ_PIPE_EN
    regs[7] <= 8'h3A;
    regs[0] <= 8'h05;
    @(negedge clk);
    issue(mk("pipe1", 0, 1, 7, 8'h3F, 8'h00, 8'h70, 3'b000, 0, 0, 0, 0, 0, 1, 8'h05, 8'h3A),
          1'b0, 8'h80, 8'h00, 8'h00, 1'b0, a1);
    issue(mk("pipe2", 0, 1, 7, 8'h44, 8'h20, 8'h00, 3'b000, 0, 0, 0, 0, 0, 1, 8'h05, 8'h3F),
          1'b0, 8'h80, 8'h00, 8'h00, 1'b0, a2);
    chk("pipe accept spacing", a2 - a1, 4);
    wait_idle();
    chk("pipe final A", regs[7], 8'h44);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
